// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port ids and the winner pick.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_DBG = 1'b1;

    // Contention winner: round-robin alternates away from the last ARB grant.
    function automatic port_id_t pick_winner(input port_id_t last_grant, input bit rr_en);
        port_id_t win;
        if (rr_en) begin
            win = ~last_grant;
        end else begin
            win = PORT_CPU;
        end
        return win;
    endfunction

endpackage

// File: rtl/dmem_arb_lock_timer.sv
// Lock hold counter: clears on clr, counts on en, flags the LOCK_MAX-1 terminal count.
module dmem_arb_lock_timer #(
    parameter int LOCK_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] TERM = CW'(LOCK_MAX - 1);

    logic [CW-1:0] count_r;

    assign done = (count_r == TERM);

    // Counter register; saturates at the terminal count until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en && !done) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with beat locking and lock timeout.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin contention (default fixed priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_lock,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_lock,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner,
    output logic                  lock_abort
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    arb_state_e state_r, state_nxt_s;
    port_id_t   last_grant_r, owner_r, win_s;
    logic       grant0_s, grant1_s, abort_s, timer_done_s;
    logic       rsp0_valid_r, rsp1_valid_r, rsp0_we_r, rsp1_we_r, lock_abort_r;

    // LOCK1 is only entered from an ARB grant to port 1, so last_grant is 1 on a
    // LOCK1 timeout and both pick modes hand the first ARB cycle to port 0.
    assign win_s = pick_winner(last_grant_r, RR_EN);

    dmem_arb_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_r == ARB),
        .en   (state_r != ARB),
        .done (timer_done_s)
    );

    // Grant decode and next-state selection.
    always_comb begin
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        abort_s     = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ARB: begin
                grant0_s = req0_valid && (!req1_valid || (win_s == PORT_CPU));
                grant1_s = req1_valid && (!req0_valid || (win_s == PORT_DBG));
                if (grant0_s && req0_lock) begin
                    state_nxt_s = LOCK0;
                end else if (grant1_s && req1_lock) begin
                    state_nxt_s = LOCK1;
                end else begin
                    state_nxt_s = ARB;
                end
            end
            LOCK0: begin
                grant0_s = req0_valid;
                if (grant0_s && !req0_lock) begin
                    state_nxt_s = ARB;
                end else if (timer_done_s) begin
                    state_nxt_s = ARB;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = LOCK0;
                end
            end
            LOCK1: begin
                grant1_s = req1_valid;
                if (grant1_s && !req1_lock) begin
                    state_nxt_s = ARB;
                end else if (timer_done_s) begin
                    state_nxt_s = ARB;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = LOCK1;
                end
            end
            default: begin
                state_nxt_s = ARB;
            end
        endcase
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            grant0_s = grant0_s;
            grant1_s = grant1_s;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Memory port mux for the accepted beat.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        if (grant0_s) begin
            mem_en    = 1'b1;
            mem_we    = req0_we;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
        end else if (grant1_s) begin
            mem_en    = 1'b1;
            mem_we    = req1_we;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
        end else begin
            mem_en = 1'b0;
        end
    end

    // FSM, grant history, response tracking and abort pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ARB;
            last_grant_r <= PORT_DBG;
            owner_r      <= PORT_CPU;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_we_r    <= 1'b0;
            rsp1_we_r    <= 1'b0;
            lock_abort_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            rsp0_valid_r <= grant0_s;
            rsp1_valid_r <= grant1_s;
            rsp0_we_r    <= grant0_s && req0_we;
            rsp1_we_r    <= grant1_s && req1_we;
            lock_abort_r <= abort_s;
            if (grant0_s) begin
                owner_r <= PORT_CPU;
            end else if (grant1_s) begin
                owner_r <= PORT_DBG;
            end else begin
                owner_r <= owner_r;
            end
            if ((state_r == ARB) && grant0_s) begin
                last_grant_r <= PORT_CPU;
            end else if ((state_r == ARB) && grant1_s) begin
                last_grant_r <= PORT_DBG;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_rdata = (rsp0_valid_r && !rsp0_we_r) ? mem_rdata : {DATA_WIDTH{1'b0}};
    assign rsp1_rdata = (rsp1_valid_r && !rsp1_we_r) ? mem_rdata : {DATA_WIDTH{1'b0}};
    assign owner      = owner_r;
    assign lock_abort = lock_abort_r;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between two requesters: port 0 is the CPU load/store path (ALU result as address, RD2 as write data), port 1 is a loader/debug master. Each beat uses a valid/ready handshake. Read and write responses return one cycle after acceptance. A requester can lock the port for multi-beat sequences, bounded by a timeout. The block sits between the datapath/loader and the data memory.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write/read data
- ADDR_WIDTH, 32, memory byte address width
- LOCK_MAX, 16, maximum consecutive cycles one port may hold a lock (≥2)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  beat request
- req0_ready / req1_ready  out  1  beat accepted when valid && ready
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_WIDTH  beat address
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data
- req0_lock / req1_lock  in  1  keep ownership after this beat
- rsp0_valid / rsp1_valid  out  1  response for the beat accepted the previous cycle
- rsp0_rdata / rsp1_rdata  out  DATA_WIDTH  read data; 0 for writes or when rsp valid is 0
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read with mem_en=1
- owner  out  1  port of the most recent grant
- lock_abort  out  1  one-cycle pulse when a lock is forcibly released

## Operation
- FSM states:
  - ARB: no lock held.
  - LOCK0 / LOCK1: the named port owns the memory; the other port's ready is 0.
- ARB: ready is combinational.
  - Only one port valid: that port is granted.
  - Both valid: the winner is chosen per Configuration.
  - The losing port's ready = 0.
- Accepted beat: the memory outputs carry that port's fields combinationally; mem_en = 1. With no beat accepted, mem_en = mem_we = 0 and the address/data outputs are 0.
- Transitions:
  - Accepted beat with lock = 1: ARB → LOCKn.
  - In LOCKn, accepted beat with lock = 0: return to ARB.
  - In LOCKn, owner idle (valid = 0): stay in LOCKn.
- Lock timer:
  - Counts cycles in LOCKn; reset to 0 on entry.
  - When the count reaches LOCK_MAX-1 with no lock-clearing beat that cycle, the next state is ARB and lock_abort pulses.
  - A beat accepted in that final cycle still completes normally.
- owner updates on every grant. last_grant records the port of the most recent ARB grant.
- Responses: rspN_valid is registered from "port N accepted".
  - Read: rspN_rdata = mem_rdata while rspN_valid = 1.
  - Write: rspN_rdata = 0.
  - There is no back-pressure on responses; requesters must sink them.

## Timing
- Acceptance to memory access: 0 cycles (same cycle). Acceptance to response: 1 cycle.
- Throughput: one beat per cycle, back-to-back, including while a lock is held.
- Reset values: state = ARB; lock counter = 0; last_grant = 1 (port 0 wins first contention); owner = 0; rsp0/1_valid = 0; lock_abort = 0.
- Combinational outputs during reset: ready = 0 and mem_en = 0.
- Reset during a pending read: the response is dropped; no rsp_valid after reset deasserts.
- A port's valid falling without acceptance is legal; no state changes.
- Both ports valid while LOCK1 times out: port 0 is served in the first ARB cycle, regardless of last_grant.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN
  - Defined: contention in ARB is resolved round-robin; the winner is the port ≠ last_grant.
  - Undefined: fixed priority; port 0 always wins contention. last_grant is still maintained, and the post-timeout rule still applies.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (ARB, LOCK0, LOCK1);
  - the port-id typedef (1 bit);
  - the constants PORT_CPU = 0 and PORT_DBG = 1.
- Sub-module dmem_arb_lock_timer: counter with clear, enable and LOCK_MAX terminal flag; async reset to 0.

## Test plan
- Port 0 read addr 0x10 alone, memory returns 0xDEADBEEF → same cycle mem_en=1, mem_we=0, mem_addr=0x10; next cycle rsp0_valid=1, rsp0_rdata=0xDEADBEEF.
- Both valid for 4 cycles, no locks, round-robin defined → grants 0,1,0,1. Macro undefined → grants 0,0,0,0; req1_ready stays 0.
- Port 1 issues 3 writes with lock=1,1,0 while port 0 is continuously valid → req0_ready=0 until the third write is accepted; port 0 is granted the following cycle.
- Port 1 locks and then idles, LOCK_MAX=16 → exactly 16 cycles of exclusion; lock_abort pulses once; port 0 is granted the next cycle.
- rst asserted the cycle after a port 0 read is accepted → rsp0_valid=0 immediately, and stays 0 after release; first contention grants port 0.
- Port 0 write 0x55 to 0x20, then read 0x20 → write response has rdata=0; read returns 0x55 one cycle after acceptance.
